// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the half-duplex UART front end
package uart_pkg;

    // Bit positions inside statusOut
    localparam int BUFFER_FULL = 0;
    localparam int PARITY_ERR  = 1;
    localparam int OVERRUN     = 2;
    localparam int RX_RUN      = 5;
    localparam int TX_PENDING  = 6;
    localparam int TX_RUN      = 7;

    // Frame shape: 1 start, DATA_BITS data (LSB first), even parity, STOP_BITS stop
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_t;

    // Even parity bit for a byte: makes the total number of ones even
    function automatic logic evenParity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - reloadable bit-period down-counter with end-of-bit and mid-bit ticks
module uart_bit_timer #(
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIVIDER_WIDTH-1:0] clkPerCycle,
    input  logic                     load,
    input  logic                     startNow,
    input  logic                     run,
    output logic                     bitTick,
    output logic                     midTick
);

    logic [DIVIDER_WIDTH-1:0] remaining;
    logic [DIVIDER_WIDTH-1:0] period;
    logic [DIVIDER_WIDTH-1:0] curRem;
    logic [DIVIDER_WIDTH-1:0] curPer;
    logic                     active;

    // Current-cycle view: load makes the next cycle the first clock of a bit,
    // startNow treats this very cycle as the first clock (used when the receiver
    // has already sampled the start bit on the detecting edge).
    // remaining = period - elapsed, so the middle (period+1)/2 is remaining == period/2.
    always_comb begin
        curRem  = startNow ? clkPerCycle : remaining;
        curPer  = startNow ? clkPerCycle : period;
        active  = startNow | run;
        bitTick = active && (curRem == '0);
        midTick = active && (curRem == (curPer >> 1));
    end

    // Count down inside a bit, reload the latched period at each bit boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            period    <= '0;
        end else if (load) begin
            remaining <= clkPerCycle;
            period    <= clkPerCycle;
        end else if (active) begin
            period    <= curPer;
            remaining <= bitTick ? curPer : curRem - 1'b1;
        end
    end

endmodule

// File: rtl/half_duplex_uart_if.sv
// rtl/half_duplex_uart_if.sv - register-style half-duplex UART with one shared byte buffer
module half_duplex_uart_if
    import uart_pkg::*;
#(
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIVIDER_WIDTH-1:0] clkPerCycle,
    input  logic [7:0]               dataIn,
    input  logic                     nWeDataIn,
    output logic [7:0]               dataOut,
    input  logic                     nCsDataOut,
    output logic [7:0]               statusOut,
    input  logic                     nCsStatusOut,
    input  logic                     serialIn,
    output logic                     serialOut,
    output logic                     isTx
);

    logic [7:0] buffer;
    logic       bufferFull;
    logic       parityError;
    logic       overrun;
    logic       txPending;
    logic       txArmed;

    uartState_t txState, txNext;
    logic [7:0] txShift;
    logic [2:0] txBitCnt;
    logic       txParity;
    logic       txRun;
    logic       txLoad;
    logic       txBitTick;
    logic       txMidTick;

    uartState_t rxState, rxNext;
    logic [7:0] rxShift;
    logic [2:0] rxBitCnt;
    logic       rxParity;
    logic       rxRun;
    logic       rxDetect;
    logic       rxDone;
    logic       rxBitTick;
    logic       rxMidTick;

    logic       writeReq;

    assign writeReq = !nWeDataIn;
    // txArmed delays the first possible load to two edges after the write,
    // giving the host a window in which bufferFull is visibly set.
    assign txLoad   = txPending && txArmed && !txRun && !rxRun;

    uart_bit_timer #(.DIVIDER_WIDTH(DIVIDER_WIDTH)) txTimer (
        .clk         (clk),
        .reset       (reset),
        .clkPerCycle (clkPerCycle),
        .load        (txLoad),
        .startNow    (1'b0),
        .run         (txRun),
        .bitTick     (txBitTick),
        .midTick     (txMidTick)
    );

    uart_bit_timer #(.DIVIDER_WIDTH(DIVIDER_WIDTH)) rxTimer (
        .clk         (clk),
        .reset       (reset),
        .clkPerCycle (clkPerCycle),
        .load        (1'b0),
        .startNow    (rxDetect),
        .run         (rxRun),
        .bitTick     (rxBitTick),
        .midTick     (rxMidTick)
    );

    // Transmit state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) txState <= IDLE;
        else       txState <= txNext;
    end

    // Transmit next state: one state per frame field, advancing on bit boundaries
    always_comb begin
        txNext = txState;
        case (txState)
            IDLE:    if (txLoad) txNext = START;
            START:   if (txBitTick) txNext = DATA;
            DATA:    if (txBitTick && txBitCnt == 3'(DATA_BITS - 1)) txNext = PARITY;
            PARITY:  if (txBitTick) txNext = STOP;
            STOP:    if (txBitTick && txBitCnt == 3'(STOP_BITS - 1)) txNext = IDLE;
            default: txNext = IDLE;
        endcase
    end

    // Transmit outputs: line level for the current field, drive enable while busy
    always_comb begin
        txRun = (txState != IDLE);
        isTx  = txRun;
        case (txState)
            START:   serialOut = 1'b0;
            DATA:    serialOut = txShift[0];
            PARITY:  serialOut = txParity;
            default: serialOut = 1'b1;
        endcase
    end

    // Transmit datapath: shift out LSB first, accumulate parity as each bit goes out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txShift  <= '0;
            txBitCnt <= '0;
            txParity <= 1'b0;
        end else if (txLoad) begin
            txShift  <= buffer;
            txBitCnt <= '0;
            txParity <= 1'b0;
        end else begin
            if (txMidTick && txState == DATA) txParity <= txParity ^ txShift[0];
            if (txBitTick) begin
                if (txState == DATA) txShift <= txShift >> 1;
                txBitCnt <= (txNext != txState) ? 3'd0 : txBitCnt + 3'd1;
            end
        end
    end

    // Receive state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rxState <= IDLE;
        else       rxState <= rxNext;
    end

    // Receive next state: start bit re-checked at mid-bit to reject glitches;
    // the frame ends after the first stop bit so the line can turn around early.
    always_comb begin
        rxNext = rxState;
        case (rxState)
            IDLE:    if (rxDetect) rxNext = rxBitTick ? DATA : START;
            START:   if (rxMidTick && serialIn) rxNext = IDLE;
                     else if (rxBitTick) rxNext = DATA;
            DATA:    if (rxBitTick && rxBitCnt == 3'(DATA_BITS - 1)) rxNext = PARITY;
            PARITY:  if (rxBitTick) rxNext = STOP;
            STOP:    if (rxBitTick) rxNext = IDLE;
            default: rxNext = IDLE;
        endcase
    end

    // Receive outputs: busy flag, start detection (muted while we drive the line), completion
    always_comb begin
        rxRun    = (rxState != IDLE);
        rxDetect = (rxState == IDLE) && !txRun && !serialIn;
        rxDone   = (rxState == STOP) && rxBitTick;
    end

    // Receive datapath: sample data and parity at mid-bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxShift  <= '0;
            rxBitCnt <= '0;
            rxParity <= 1'b0;
        end else begin
            if (rxDetect) rxBitCnt <= '0;
            if (rxState == DATA && rxMidTick) rxShift <= {serialIn, rxShift[7:1]};
            if (rxState == DATA && rxBitTick) rxBitCnt <= rxBitCnt + 3'd1;
            if (rxState == PARITY && rxMidTick) rxParity <= serialIn;
        end
    end

    // Shared buffer and status flags; later statements take priority
    // (host write beats an rx byte on the same edge, error sets beat the status-read clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer      <= '0;
            bufferFull  <= 1'b0;
            parityError <= 1'b0;
            overrun     <= 1'b0;
            txPending   <= 1'b0;
            txArmed     <= 1'b0;
        end else begin
            txArmed <= txPending && !txLoad;
            if (!nCsStatusOut) begin
                parityError <= 1'b0;
                overrun     <= 1'b0;
            end
            if (!nCsDataOut && !txPending) bufferFull <= 1'b0;
            if (rxDone) begin
                if (writeReq || bufferFull) begin
                    overrun <= 1'b1;
                end else begin
                    buffer     <= rxShift;
                    bufferFull <= 1'b1;
                    if (evenParity(rxShift) != rxParity) parityError <= 1'b1;
                end
            end
            if (writeReq) begin
                if (bufferFull) begin
                    overrun <= 1'b1;
                end else begin
                    buffer     <= dataIn;
                    bufferFull <= 1'b1;
                    txPending  <= 1'b1;
                end
            end
            if (txLoad) begin
                bufferFull <= 1'b0;
                txPending  <= 1'b0;
            end
        end
    end

    // Register views for the host
    always_comb begin
        dataOut                = buffer;
        statusOut              = '0;
        statusOut[BUFFER_FULL] = bufferFull;
        statusOut[PARITY_ERR]  = parityError;
        statusOut[OVERRUN]     = overrun;
        statusOut[RX_RUN]      = rxRun;
        statusOut[TX_PENDING]  = txPending;
        statusOut[TX_RUN]      = txRun;
    end

endmodule

// File: tb/tb_half_duplex_uart_if.sv
// tb/tb_half_duplex_uart_if.sv - two UARTs on one pulled-up wire plus a raw frame injector
`timescale 1ns/1ps
module tb_half_duplex_uart_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpcA, cpcB;
    logic [7:0]  dinA, dinB, doutA, doutB, statA, statB;
    logic        nWeA, nWeB, nCsDA, nCsDB, nCsSA, nCsSB;
    logic        soA, soB, txA, txB;
    logic        inj;
    wire         line;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    // Open-drain wire: any active driver or the injector pulls it low
    assign line = ~((txA & ~soA) | (txB & ~soB) | ~inj);

    half_duplex_uart_if dutA (
        .clk(clk), .reset(reset), .clkPerCycle(cpcA), .dataIn(dinA), .nWeDataIn(nWeA),
        .dataOut(doutA), .nCsDataOut(nCsDA), .statusOut(statA), .nCsStatusOut(nCsSA),
        .serialIn(line), .serialOut(soA), .isTx(txA)
    );

    half_duplex_uart_if dutB (
        .clk(clk), .reset(reset), .clkPerCycle(cpcB), .dataIn(dinB), .nWeDataIn(nWeB),
        .dataOut(doutB), .nCsDataOut(nCsDB), .statusOut(statB), .nCsStatusOut(nCsSB),
        .serialIn(line), .serialOut(soB), .isTx(txB)
    );

    typedef struct {
        logic        src;      // 0 = A sends, 1 = B sends
        logic [7:0]  data;
        logic [15:0] cpc;
        logic [7:0]  expData;
        logic [7:0]  expStat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitStat(input logic side, input int bitIdx, input logic val,
                            input int budget, input string name);
        int n = 0;
        while (((side ? statB[bitIdx] : statA[bitIdx]) !== val) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(side ? statB[bitIdx] : statA[bitIdx]), 32'(val));
    endtask

    task automatic writeByte(input logic side, input logic [7:0] d);
        if (side) begin dinB = d; nWeB = 1'b0; end
        else      begin dinA = d; nWeA = 1'b0; end
        @(negedge clk);
        nWeA = 1'b1;
        nWeB = 1'b1;
    endtask

    task automatic readAck(input logic side);
        if (side) nCsDB = 1'b0; else nCsDA = 1'b0;
        @(negedge clk);
        nCsDA = 1'b1;
        nCsDB = 1'b1;
    endtask

    task automatic statusRead(input logic side);
        if (side) nCsSB = 1'b0; else nCsSA = 1'b0;
        @(negedge clk);
        nCsSA = 1'b1;
        nCsSB = 1'b1;
    endtask

    // Raw frame on the wire: start, 8 data LSB first, given parity bit, 2 stop
    task automatic sendRaw(input logic [7:0] d, input logic par, input int p);
        logic [11:0] bits;
        bits = {2'b11, par, d, 1'b0};
        for (int b = 0; b < 12; b++) begin
            inj = bits[b];
            for (int c = 0; c <= p; c++) @(negedge clk);
        end
        inj = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        int  lowCnt, txCnt, isTxBad;
        bit  lowDone;

        vecs[0] = '{1'b1, 8'h55, 16'd0, 8'h55, 8'h01};
        vecs[1] = '{1'b0, 8'h56, 16'd0, 8'h56, 8'h01};
        vecs[2] = '{1'b0, 8'h78, 16'd0, 8'h78, 8'h01};
        vecs[3] = '{1'b1, 8'hC3, 16'd2, 8'hC3, 8'h01};
        vecs[4] = '{1'b0, 8'h80, 16'd1, 8'h80, 8'h01};
        vecs[5] = '{1'b1, 8'h3C, 16'd5, 8'h3C, 8'h01};

        reset = 1'b1;
        cpcA = 16'd0; cpcB = 16'd0;
        dinA = 8'h00; dinB = 8'h00;
        nWeA = 1'b1; nWeB = 1'b1; nCsDA = 1'b1; nCsDB = 1'b1; nCsSA = 1'b1; nCsSB = 1'b1;
        inj = 1'b1;
        repeat (3) @(negedge clk);
        check("reset statA", 32'(statA), 32'h00);
        check("reset statB", 32'(statB), 32'h00);
        check("reset doutA", 32'(doutA), 32'h00);
        check("reset soA", 32'(soA), 32'h1);
        check("reset isTxA", 32'(txA), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Write timing: full after the write edge and the next, cleared by the load edge
        t0 = $time;
        writeByte(1'b0, 8'h3B);
        check("bf after N", 32'(statA[0]), 32'h1);
        @(negedge clk);
        check("bf after N+1", 32'(statA[0]), 32'h1);
        check("txPending after N+1", 32'(statA[6]), 32'h1);
        @(negedge clk);
        check("bf after N+2", 32'(statA[0]), 32'h0);
        check("isTx at load", 32'(txA), 32'h1);
        check("start bit level", 32'(soA), 32'h0);
        waitStat(1'b1, 0, 1'b1, 30, "rx 3B arrival");
        check("peer data 3B", 32'(doutB), 32'h3B);
        check("peer stat 3B", 32'(statB), 32'h01);
        readAck(1'b1);
        waitStat(1'b0, 7, 1'b0, 30, "tx 3B end");

        // Back-to-back frames
        writeByte(1'b0, 8'h97);
        waitStat(1'b0, 0, 1'b0, 10, "b2b load 97");
        writeByte(1'b0, 8'h12);
        waitStat(1'b1, 0, 1'b1, 40, "b2b rx 97");
        check("b2b data 97", 32'(doutB), 32'h97);
        check("b2b stat 97", 32'(statB), 32'h01);
        readAck(1'b1);
        waitStat(1'b0, 0, 1'b0, 40, "b2b load 12");
        writeByte(1'b0, 8'h34);
        waitStat(1'b1, 0, 1'b1, 40, "b2b rx 12");
        check("b2b data 12", 32'(doutB), 32'h12);
        check("b2b stat 12", 32'(statB), 32'h01);
        readAck(1'b1);
        waitStat(1'b1, 0, 1'b1, 40, "b2b rx 34");
        check("b2b data 34", 32'(doutB), 32'h34);
        check("b2b stat 34", 32'(statB), 32'h01);
        readAck(1'b1);
        waitStat(1'b0, 7, 1'b0, 30, "b2b tx end");

        // Table: turnaround and several bit periods
        for (int i = 0; i < 6; i++) begin
            cpcA = vecs[i].cpc;
            cpcB = vecs[i].cpc;
            writeByte(vecs[i].src, vecs[i].data);
            waitStat(~vecs[i].src, 0, 1'b1, 14 * (int'(vecs[i].cpc) + 1) + 20, $sformatf("vec%0d arrival", i));
            check($sformatf("vec%0d data", i),
                  32'(vecs[i].src ? doutA : doutB), 32'(vecs[i].expData));
            check($sformatf("vec%0d stat", i),
                  32'(vecs[i].src ? statA : statB), 32'(vecs[i].expStat));
            readAck(~vecs[i].src);
            check($sformatf("vec%0d stat after read", i),
                  32'(vecs[i].src ? statA : statB), 32'h00);
            waitStat(vecs[i].src, 7, 1'b0, 4 * (int'(vecs[i].cpc) + 1) + 10, $sformatf("vec%0d tx end", i));
            check($sformatf("vec%0d sender stat", i),
                  32'(vecs[i].src ? statB : statA), 32'h00);
            if (i == 2) check("seven bytes under 10us", 32'(($time - t0) < 10000), 32'h1);
        end

        // Bit timing at clkPerCycle = 9
        cpcA = 16'd9;
        cpcB = 16'd9;
        writeByte(1'b0, 8'h01);
        waitStat(1'b0, 7, 1'b1, 10, "p9 tx start");
        lowCnt = 0; txCnt = 0; isTxBad = 0; lowDone = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (txA) txCnt++;
            if (!lowDone) begin
                if (!soA) lowCnt++;
                else lowDone = 1'b1;
            end
            if (txA !== statA[7]) isTxBad++;
            @(negedge clk);
        end
        check("p9 start bit clks", 32'(lowCnt), 32'd10);
        check("p9 frame clks", 32'(txCnt), 32'd120);
        check("p9 isTx vs txRun", 32'(isTxBad), 32'd0);
        check("p9 peer data", 32'(doutB), 32'h01);
        check("p9 peer stat", 32'(statB), 32'h01);
        readAck(1'b1);

        // Start-bit glitch at clkPerCycle = 3
        cpcA = 16'd3;
        cpcB = 16'd3;
        inj = 1'b0;
        @(negedge clk);
        inj = 1'b1;
        check("glitch rxRun set", 32'(statA[5]), 32'h1);
        repeat (3) @(negedge clk);
        check("glitch aborted", 32'(statA), 32'h00);

        // Bad parity, status clear, then overrun keeps the first byte
        cpcA = 16'd0;
        cpcB = 16'd0;
        @(negedge clk);
        sendRaw(8'h03, 1'b1, 0);
        @(negedge clk);
        check("parity err stat", 32'(statA), 32'h03);
        check("parity err data", 32'(doutA), 32'h03);
        statusRead(1'b0);
        check("status read clears", 32'(statA), 32'h01);
        sendRaw(8'hA5, 1'b0, 0);
        @(negedge clk);
        check("overrun stat", 32'(statA), 32'h05);
        check("overrun keeps data", 32'(doutA), 32'h03);

        // Asynchronous reset in the middle of a frame
        statusRead(1'b0);
        readAck(1'b0);
        cpcA = 16'd9;
        writeByte(1'b0, 8'hF0);
        repeat (30) @(negedge clk);
        check("pre-reset isTx", 32'(txA), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async reset soA", 32'(soA), 32'h1);
        check("async reset isTx", 32'(txA), 32'h0);
        check("async reset statA", 32'(statA), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post-reset line", 32'(line), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/half_duplex_uart_if.md
Name: half_duplex_uart_if

Overview:
- Byte-wide, register-style half-duplex UART front end for a single shared serial line, used for ISO 7816-3 style links.
- A single 8-bit data buffer is shared by the transmitter (host writes) and the receiver (line data).
- Serial I/O is split into serialIn, serialOut and an isTx drive-enable, so the top level builds the open-drain/tri-state line.
- Bit timing is programmable at run time through clkPerCycle.

Parameters:
- DIVIDER_WIDTH, 16, width of clkPerCycle and of the internal bit-period counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clkPerCycle  in  DIVIDER_WIDTH  bit period minus one, in clk cycles (0 means 1 clk per bit).
- dataIn  in  8  byte to transmit.
- nWeDataIn  in  1  active-low write strobe, sampled on clk.
- dataOut  out  8  current buffer contents; always driven.
- nCsDataOut  in  1  active-low read acknowledge, sampled on clk.
- statusOut  out  8  status word; always driven.
- nCsStatusOut  in  1  active-low status read; clears sticky error bits.
- serialIn  in  1  line receive; idle high.
- serialOut  out  1  line transmit; idle high.
- isTx  out  1  high while this block drives the line.

Behaviour:
- Reset values (asynchronous): buffer=0, dataOut=0, all status bits 0, serialOut=1, isTx=0, counters 0.
- Frame format:
  - 1 start bit (0), 8 data bits LSB first, even parity bit, 2 stop bits (1).
  - Each bit lasts clkPerCycle+1 clk cycles.
- statusOut bit map:
  - [0] bufferFull.
  - [1] parityError (sticky).
  - [2] overrun (sticky).
  - [4:3] always 0.
  - [5] rxRun.
  - [6] txPending.
  - [7] txRun.
- isTx equals txRun.
- Write path:
  - Edge N with nWeDataIn=0 and bufferFull=0: buffer<=dataIn, bufferFull=1, txPending=1.
  - Write while bufferFull=1: ignored, overrun<=1.
- Tx start:
  - Condition: txPending=1, txRun=0 and rxRun=0.
  - The earliest load is edge N+2 after the write at edge N.
  - On load: shift register<=buffer, bufferFull=0, txPending=0, txRun=1, serialOut drives the start bit from that edge.
  - bufferFull therefore reads 1 for at least edges N+1..N+2 and reads 0 by edge N+3 when the line is idle.
- Tx end: txRun clears on the edge ending the second stop bit; serialOut=1.
  - A further pending byte may start on the next edge (back-to-back frames allowed).
- Rx engine:
  - Receive is disabled while txRun=1; the block never receives its own echo.
  - When idle, a 0 sampled on serialIn sets rxRun and starts the frame.
  - Each bit is sampled at its middle (count (clkPerCycle+1)/2); for period 1 the bit is sampled in its single cycle.
  - The frame is complete after the parity bit plus the first stop bit; rxRun clears then.
  - If the start bit reads 1 at its mid-sample, the frame is aborted as a glitch and rxRun clears.
- Rx delivery:
  - bufferFull=0: buffer<=byte, bufferFull=1; parityError<=1 if even parity fails.
  - bufferFull=1 (including a pending tx byte): byte dropped, overrun<=1.
- Read:
  - dataOut continuously reflects the buffer.
  - Edge with nCsDataOut=0 and txPending=0: bufferFull<=0; data is retained on dataOut.
  - With txPending=1 the read acknowledge is ignored.
- Status read: an edge with nCsStatusOut=0 clears parityError and overrun after that cycle.
- Contention: a write and an rx completion on the same edge → the write wins, the rx byte is dropped, overrun<=1.
- A clkPerCycle change takes effect at the next frame start.
- Reset asserted mid-frame aborts immediately; the line returns to idle 1.

Decomposition:
- Shared package, uart_pkg:
  - Status bit index constants: BUFFER_FULL=0, PARITY_ERR=1, OVERRUN=2, RX_RUN=5, TX_PENDING=6, TX_RUN=7.
  - Frame constants: data bits 8, stop bits 2.
  - FSM state enums: IDLE/START/DATA/PARITY/STOP.
- One sub-module is natural: uart_bit_timer, a reloadable down-counter that produces a bit-tick and a mid-bit tick from clkPerCycle.
  - Instantiate it twice, once for tx and once for rx.

Test Plan:
- Two instances on one pulled-up wire, clkPerCycle=0.
  - Write 0x3B → bufferFull=1 one edge later, 0 three edges later.
  - Peer sees bufferFull=1 and dataOut=0x3B after the frame.
- Back-to-back writes 0x97, 0x12, 0x34 (each write waits on bufferFull=0) → peer reads 0x97, 0x12, 0x34 in order with no parity or overrun flags.
- Direction turnaround: peer sends 0x55 → local reads 0x55; then local sends 0x56, 0x78 → peer reads both.
  - All seven bytes complete well within 10 µs at a 10 ns clk.
- clkPerCycle=9 → measured start-bit low time = 10 clks; frame length 12 bit periods; isTx high exactly during the frame.
- Inject a byte with bad parity on serialIn → parityError=1; an nCsStatusOut pulse clears it.
- Deliver a second rx byte without reading the first → overrun=1 and dataOut keeps the first byte.
